// File: rtl/ysyx_24110015_lsu_sram_if.sv
// Request/response channel between the LSU (master) and the SRAM responder (slave).
// Both channels use a valid/ready handshake.
interface ysyx_24110015_lsu_sram_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_wmask, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_wmask, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/ysyx_24110015_lsu_sram.sv
// Word-organised SRAM responder for LSU load/store requests.
// Serves one request at a time with a programmable response latency.
module ysyx_24110015_lsu_sram #(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 1
) (
    input logic                     clk,
    input logic                     rst,
    ysyx_24110015_lsu_sram_if.slave bus
);

    localparam int unsigned         IDX_W    = $clog2(DEPTH_WORDS);
    localparam int unsigned         CNT_W    = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0]    CNT_INIT = CNT_W'((LATENCY >= 2) ? LATENCY - 2 : 0);
    localparam logic [29:0]         DEPTH_30 = 30'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rdata_q;
    logic        err_q;

    logic [29:0]      word_off;
    logic [IDX_W-1:0] idx;
    logic             addr_err;
    logic             accept;
    logic             rsp_fire;

    // Word offset taken on the word-aligned address; the range check on the full
    // address rejects anything below the base instead of letting it wrap.
    assign word_off = bus.req_addr[31:2] - ADDR_BASE[31:2];
    assign idx      = word_off[IDX_W-1:0];
    assign addr_err = (bus.req_addr < ADDR_BASE) || (word_off >= DEPTH_30);

    assign bus.req_ready = (state == IDLE) && rst;
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

    assign accept   = bus.req_valid && bus.req_ready;
    assign rsp_fire = (state == RESP) && bus.rsp_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Array is deliberately outside reset so contents survive a mid-run reset.
    always_ff @(posedge clk) begin
        if (accept && bus.req_wen && !addr_err) begin
            for (int unsigned lane = 0; lane < 4; lane++) begin
                if (bus.req_wmask[lane]) begin
                    mem[idx][8*lane +: 8] <= bus.req_wdata[8*lane +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            err_q   <= addr_err;
            rdata_q <= (!bus.req_wen && !addr_err) ? mem[idx] : '0;
        end else if (rsp_fire) begin
            err_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ysyx_24110015_lsu_sram.sv
// Directed bench for the LSU SRAM responder: three instances at latency 1, 3 and 4.
module tb_ysyx_24110015_lsu_sram;

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic [1:0]  sel           = 2'd0;
    logic        drv_valid     = 1'b0;
    logic        drv_wen       = 1'b0;
    logic [31:0] drv_addr      = '0;
    logic [31:0] drv_wdata     = '0;
    logic [3:0]  drv_wmask     = '0;
    logic        drv_rsp_ready = 1'b1;

    int checks   = 0;
    int failures = 0;

    logic        s_req_ready;
    logic        s_rsp_valid;
    logic        s_rsp_err;
    logic [31:0] s_rsp_rdata;

    vec_t vecs[20];

    always #5 clk = ~clk;

    ysyx_24110015_lsu_sram_if if_l1 ();
    ysyx_24110015_lsu_sram_if if_l3 ();
    ysyx_24110015_lsu_sram_if if_l4 ();

    assign if_l1.req_valid = drv_valid && (sel == 2'd0);
    assign if_l3.req_valid = drv_valid && (sel == 2'd1);
    assign if_l4.req_valid = drv_valid && (sel == 2'd2);

    assign if_l1.req_wen = drv_wen;     assign if_l3.req_wen = drv_wen;     assign if_l4.req_wen = drv_wen;
    assign if_l1.req_addr = drv_addr;   assign if_l3.req_addr = drv_addr;   assign if_l4.req_addr = drv_addr;
    assign if_l1.req_wdata = drv_wdata; assign if_l3.req_wdata = drv_wdata; assign if_l4.req_wdata = drv_wdata;
    assign if_l1.req_wmask = drv_wmask; assign if_l3.req_wmask = drv_wmask; assign if_l4.req_wmask = drv_wmask;
    assign if_l1.rsp_ready = drv_rsp_ready;
    assign if_l3.rsp_ready = drv_rsp_ready;
    assign if_l4.rsp_ready = drv_rsp_ready;

    ysyx_24110015_lsu_sram #(.LATENCY(1)) u_l1 (.clk(clk), .rst(rst), .bus(if_l1));
    ysyx_24110015_lsu_sram #(.LATENCY(3)) u_l3 (.clk(clk), .rst(rst), .bus(if_l3));
    ysyx_24110015_lsu_sram #(.LATENCY(4)) u_l4 (.clk(clk), .rst(rst), .bus(if_l4));

    always_comb begin
        case (sel)
            2'd1: begin
                s_req_ready = if_l3.req_ready; s_rsp_valid = if_l3.rsp_valid;
                s_rsp_err   = if_l3.rsp_err;   s_rsp_rdata = if_l3.rsp_rdata;
            end
            2'd2: begin
                s_req_ready = if_l4.req_ready; s_rsp_valid = if_l4.rsp_valid;
                s_rsp_err   = if_l4.rsp_err;   s_rsp_rdata = if_l4.rsp_rdata;
            end
            default: begin
                s_req_ready = if_l1.req_ready; s_rsp_valid = if_l1.rsp_valid;
                s_rsp_err   = if_l1.rsp_err;   s_rsp_rdata = if_l1.rsp_rdata;
            end
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Called just after a negedge; returns just after the negedge following the handshake.
    task automatic do_req(input logic [1:0] s, input int unsigned lat, input vec_t v, input string tag);
        sel           = s;
        drv_wen       = v.wen;
        drv_addr      = v.addr;
        drv_wdata     = v.wdata;
        drv_wmask     = v.wmask;
        drv_rsp_ready = 1'b1;
        drv_valid     = 1'b1;
        #1;
        chk({tag, ".req_ready_idle"}, {31'd0, s_req_ready}, 32'd1);
        @(posedge clk);
        #1 drv_valid = 1'b0;
        for (int unsigned j = 0; j < lat; j++) begin
            @(negedge clk);
            chk({tag, ".rsp_valid_timing"}, {31'd0, s_rsp_valid}, {31'd0, (j == lat - 1)});
            chk({tag, ".req_ready_busy"}, {31'd0, s_req_ready}, 32'd0);
        end
        chk({tag, ".rdata"}, s_rsp_rdata, v.exp_rdata);
        chk({tag, ".err"}, {31'd0, s_rsp_err}, {31'd0, v.exp_err});
        @(negedge clk);
        chk({tag, ".rsp_valid_after"}, {31'd0, s_rsp_valid}, 32'd0);
        chk({tag, ".req_ready_after"}, {31'd0, s_req_ready}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;

        vecs[0]  = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b0, 32'h8000_0010, 32'h0000_0000, 4'h0, 32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b0, 32'h8000_0012, 32'h0000_0000, 4'h0, 32'hDEAD_BEEF, 1'b0};
        vecs[3]  = '{1'b1, 32'h8000_0020, 32'h1122_3344, 4'hF, 32'h0000_0000, 1'b0};
        vecs[4]  = '{1'b1, 32'h8000_0020, 32'h0000_AA00, 4'b0010, 32'h0000_0000, 1'b0};
        vecs[5]  = '{1'b0, 32'h8000_0023, 32'h0000_0000, 4'h0, 32'h1122_AA44, 1'b0};
        vecs[6]  = '{1'b1, 32'h8000_0020, 32'hFFFF_FFFF, 4'b0000, 32'h0000_0000, 1'b0};
        vecs[7]  = '{1'b0, 32'h8000_0020, 32'h0000_0000, 4'h0, 32'h1122_AA44, 1'b0};
        vecs[8]  = '{1'b1, 32'h8000_0000, 32'hCAFE_F00D, 4'hF, 32'h0000_0000, 1'b0};
        vecs[9]  = '{1'b0, 32'h7FFF_FFFC, 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b1};
        vecs[10] = '{1'b0, 32'h8000_1000, 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b1};
        vecs[11] = '{1'b1, 32'h8000_1000, 32'h1234_5678, 4'hF, 32'h0000_0000, 1'b1};
        vecs[12] = '{1'b0, 32'h8000_0000, 32'h0000_0000, 4'h0, 32'hCAFE_F00D, 1'b0};
        vecs[13] = '{1'b1, 32'h8000_0000, 32'hFFFF_FF11, 4'b0001, 32'h0000_0000, 1'b0};
        vecs[14] = '{1'b0, 32'h8000_0000, 32'h0000_0000, 4'h0, 32'hCAFE_F011, 1'b0};
        vecs[15] = '{1'b1, 32'h8000_0FFC, 32'h0102_0304, 4'hF, 32'h0000_0000, 1'b0};
        vecs[16] = '{1'b1, 32'h8000_0FFC, 32'hA5B6_C7D8, 4'b1001, 32'h0000_0000, 1'b0};
        vecs[17] = '{1'b0, 32'h8000_0FFC, 32'h0000_0000, 4'h0, 32'hA502_03D8, 1'b0};
        vecs[18] = '{1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b1};
        vecs[19] = '{1'b0, 32'h8000_0010, 32'h0000_0000, 4'h0, 32'hDEAD_BEEF, 1'b0};

        // Reset: all instances held for three cycles.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            for (int s = 0; s < 3; s++) begin
                sel = 2'(s);
                #0;
                chk("rst.req_ready", {31'd0, s_req_ready}, 32'd0);
                chk("rst.rsp_valid", {31'd0, s_rsp_valid}, 32'd0);
                chk("rst.rsp_err", {31'd0, s_rsp_err}, 32'd0);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            #0;
            chk("post_rst.req_ready", {31'd0, s_req_ready}, 32'd1);
            chk("post_rst.rsp_valid", {31'd0, s_rsp_valid}, 32'd0);
            chk("post_rst.rsp_rdata", s_rsp_rdata, 32'd0);
        end

        // Latency-1 table.
        for (int i = 0; i < 20; i++) begin
            do_req(2'd0, 1, vecs[i], $sformatf("vec%0d", i));
        end

        // Latency 3 with response backpressure.
        v = '{1'b1, 32'h8000_0040, 32'h0BAD_CAFE, 4'hF, 32'h0000_0000, 1'b0};
        do_req(2'd1, 3, v, "l3_store");
        sel           = 2'd1;
        drv_wen       = 1'b0;
        drv_addr      = 32'h8000_0040;
        drv_rsp_ready = 1'b0;
        drv_valid     = 1'b1;
        #1;
        chk("l3_bp.req_ready_idle", {31'd0, s_req_ready}, 32'd1);
        @(posedge clk);
        #1 drv_valid = 1'b0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            chk("l3_bp.rsp_valid", {31'd0, s_rsp_valid}, {31'd0, (j >= 2)});
            chk("l3_bp.req_ready", {31'd0, s_req_ready}, 32'd0);
            if (j >= 2) begin
                chk("l3_bp.rdata_stable", s_rsp_rdata, 32'h0BAD_CAFE);
                chk("l3_bp.err", {31'd0, s_rsp_err}, 32'd0);
            end
        end
        drv_rsp_ready = 1'b1;
        @(negedge clk);
        chk("l3_bp.rsp_valid_after", {31'd0, s_rsp_valid}, 32'd0);
        chk("l3_bp.req_ready_after", {31'd0, s_req_ready}, 32'd1);

        // Latency 4: reset during WAIT after a store; the store stays committed.
        sel       = 2'd2;
        drv_wen   = 1'b1;
        drv_addr  = 32'h8000_0080;
        drv_wdata = 32'h5A5A_5A5A;
        drv_wmask = 4'hF;
        drv_valid = 1'b1;
        #1;
        chk("l4_rst.req_ready_idle", {31'd0, s_req_ready}, 32'd1);
        @(posedge clk);
        #1 drv_valid = 1'b0;
        @(negedge clk);
        chk("l4_rst.rsp_valid_wait", {31'd0, s_rsp_valid}, 32'd0);
        rst = 1'b0;
        #1;
        chk("l4_rst.req_ready_in_rst", {31'd0, s_req_ready}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            chk("l4_rst.rsp_valid_dropped", {31'd0, s_rsp_valid}, 32'd0);
        end
        v = '{1'b0, 32'h8000_0080, 32'h0000_0000, 4'h0, 32'h5A5A_5A5A, 1'b0};
        do_req(2'd2, 4, v, "l4_load");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
